// File: rtl/fft_bin_collector.sv
// Captures finished DFT bins, squares them into |X[k]|^2 over a two-stage pipeline
// and buffers {power, k} in a small FIFO drained over valid/ready.
module fft_bin_collector #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic [IDX_W-1:0]         i_samp_number,
    input  logic                     i_bin_valid,
    input  logic [31:0]              i_bin_data,
    input  logic [IDX_W-1:0]         i_bin_index,
    output logic                     o_stall,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_data,
    output logic [IDX_W-1:0]         o_index,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int OCC_W = LVL_W + 1;

    logic                     r_s1_valid;
    logic signed [15:0]       r_s1_re;
    logic signed [15:0]       r_s1_im;
    logic [IDX_W-1:0]         r_s1_idx;
    logic                     r_s2_valid;
    logic [31:0]              r_s2_pwr;
    logic [IDX_W-1:0]         r_s2_idx;
    logic [31:0]              r_mem_pwr [DEPTH];
    logic [IDX_W-1:0]         r_mem_idx [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [LVL_W-1:0]         r_level;
    logic                     r_overflow;
    logic                     r_done;

    logic [OCC_W-1:0]         w_occ;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_push;
    logic signed [31:0]       w_re_ext;
    logic signed [31:0]       w_im_ext;
    logic signed [31:0]       w_re_sq;
    logic signed [31:0]       w_im_sq;
    logic [31:0]              w_pwr;
    logic [IDX_W-1:0]         w_last_idx;
    logic                     w_head_last;

    // In-flight pipeline entries count against capacity so nothing accepted is ever lost.
    assign w_occ    = OCC_W'(r_level) + OCC_W'(r_s1_valid) + OCC_W'(r_s2_valid);
    assign w_stall  = (w_occ >= OCC_W'(DEPTH));
    assign w_accept = i_bin_valid & ~w_stall & ~i_clear;
    assign w_push   = r_s2_valid;
    assign w_pop    = o_valid & i_ready;

    // Worst case is 2^31 (both parts -32768); it fits unsigned 32 bits.
    assign w_re_ext = 32'(r_s1_re);
    assign w_im_ext = 32'(r_s1_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_pwr    = w_re_sq + w_im_sq;

    assign w_last_idx  = i_samp_number - IDX_W'(1);
    assign w_head_last = (i_samp_number != '0) && (r_mem_idx[r_rd_ptr] == w_last_idx);

    assign o_stall    = w_stall;
    assign o_valid    = (r_level != '0);
    assign o_data     = o_valid ? r_mem_pwr[r_rd_ptr] : '0;
    assign o_index    = o_valid ? r_mem_idx[r_rd_ptr] : '0;
    assign o_last     = o_valid & w_head_last;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_done     = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_pwr   <= '0;
            r_s2_idx   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else if (i_clear) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_re  <= i_bin_data[31:16];
                r_s1_im  <= i_bin_data[15:0];
                r_s1_idx <= i_bin_index;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_pwr <= w_pwr;
                r_s2_idx <= r_s1_idx;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (i_bin_valid & w_stall) r_overflow <= 1'b1;
            r_done <= w_pop & o_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push & ~i_clear) begin
            r_mem_pwr[r_wr_ptr] <= r_s2_pwr;
            r_mem_idx[r_wr_ptr] <= r_s2_idx;
        end
    end

endmodule

// File: tb/tb_fft_bin_collector.sv
// Bench for fft_bin_collector: constant vector table, hand-built corner sequences
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_fft_bin_collector;
    localparam int DEPTH = 16;
    localparam int IDX_W = 12;

    logic                   clk;
    logic                   rst;
    logic                   i_clear;
    logic [IDX_W-1:0]       i_samp_number;
    logic                   i_bin_valid;
    logic [31:0]            i_bin_data;
    logic [IDX_W-1:0]       i_bin_index;
    logic                   o_stall;
    logic                   o_valid;
    logic                   i_ready;
    logic [31:0]            o_data;
    logic [IDX_W-1:0]       o_index;
    logic                   o_last;
    logic [$clog2(DEPTH):0] o_level;
    logic                   o_overflow;
    logic                   o_done;

    fft_bin_collector #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (i_clear),
        .i_samp_number (i_samp_number),
        .i_bin_valid   (i_bin_valid),
        .i_bin_data    (i_bin_data),
        .i_bin_index   (i_bin_index),
        .o_stall       (o_stall),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_index       (o_index),
        .o_last        (o_last),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bins in flight and FIFO contents as plain queues.
    typedef struct {
        logic [31:0]      pwr;
        logic [IDX_W-1:0] idx;
    } ent_t;

    ent_t m_q[$];
    ent_t m_st1[$];
    ent_t m_st2[$];
    bit   m_ovf;
    bit   m_done;

    function automatic logic [31:0] ref_power(input logic [31:0] d);
        longint re, im;
        re = longint'($signed(d[31:16]));
        im = longint'($signed(d[15:0]));
        return 32'(re * re + im * im);
    endfunction

    function automatic int m_occ();
        return m_q.size() + m_st1.size() + m_st2.size();
    endfunction

    function automatic bit m_is_last(input logic [IDX_W-1:0] k);
        int n;
        n = int'(i_samp_number);
        return (n != 0) && (int'(k) == n - 1);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_st1.delete();
        m_st2.delete();
        m_ovf  = 0;
        m_done = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        bit   stall;
        if (i_clear) begin
            model_reset();
            return;
        end
        stall  = (m_occ() >= DEPTH);
        m_done = 0;
        if (m_q.size() > 0 && i_ready) begin
            m_done = m_is_last(m_q[0].idx);
            void'(m_q.pop_front());
        end
        if (m_st2.size() > 0) m_q.push_back(m_st2.pop_front());
        if (m_st1.size() > 0) m_st2.push_back(m_st1.pop_front());
        if (i_bin_valid) begin
            if (stall) m_ovf = 1;
            else begin
                e.pwr = ref_power(i_bin_data);
                e.idx = i_bin_index;
                m_st1.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        bit v;
        v = (m_q.size() > 0);
        chk("valid", o_valid, v);
        if (v) begin
            chk("data", o_data, m_q[0].pwr);
            chk("index", o_index, m_q[0].idx);
            chk("last", o_last, m_is_last(m_q[0].idx));
        end else begin
            chk("data_empty", o_data, 0);
            chk("index_empty", o_index, 0);
            chk("last_empty", o_last, 0);
        end
        chk("level", o_level, m_q.size());
        chk("stall", o_stall, m_occ() >= DEPTH);
        chk("overflow", o_overflow, m_ovf);
        chk("done", o_done, m_done);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        i_bin_valid = 0;
        i_clear     = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_index"}, o_index, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_level"}, o_level, 0);
        chk({tag, "_stall"}, o_stall, 0);
        chk({tag, "_overflow"}, o_overflow, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    // Presents one fresh bin per cycle only while the model says the core may run.
    task automatic feed_core(input int cycles, input int base_idx, output int accepted);
        accepted = 0;
        for (int c = 0; c < cycles; c++) begin
            i_bin_valid = (m_occ() < DEPTH);
            i_bin_data  = $urandom;
            i_bin_index = IDX_W'(base_idx + accepted);
            if (i_bin_valid) accepted++;
            cyc();
        end
        i_bin_valid = 0;
    endtask

    typedef struct {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
        logic [31:0]      exp_pwr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, done_cnt, last_cnt, seen, prev_last_pop;

        vecs[0] = '{32'h0003_FFFC, 12'd5,   32'd25};
        vecs[1] = '{32'h8000_8000, 12'd7,   32'h8000_0000};
        vecs[2] = '{32'h7FFF_0000, 12'd9,   32'h3FFF_0001};
        vecs[3] = '{32'h0000_0000, 12'd0,   32'h0000_0000};
        vecs[4] = '{32'hFFFF_0001, 12'd1,   32'h0000_0002};
        vecs[5] = '{32'h0001_8000, 12'hFFF, 32'h4000_0001};

        rst = 1; i_clear = 0; i_bin_valid = 0; i_bin_data = 0; i_bin_index = 0;
        i_ready = 0; i_samp_number = 12'd16;
        model_reset();
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 0;

        // Single-bin latency and power vectors.
        for (int i = 0; i < 6; i++) begin
            i_ready = 1;
            i_bin_valid = 1; i_bin_data = vecs[i].data; i_bin_index = vecs[i].idx;
            cyc();
            i_bin_valid = 0;
            cyc();
            chk("vec_not_yet_valid", o_valid, 0);
            cyc();
            chk("vec_valid", o_valid, 1);
            chk("vec_data", o_data, vecs[i].exp_pwr);
            chk("vec_index", o_index, vecs[i].idx);
            cyc();
            chk("vec_empty_after", o_level, 0);
        end

        // Back-pressure: consumer stalled, core obeys o_stall.
        i_ready = 0;
        feed_core(30, 0, acc);
        chk("bp_accepted", acc, 16);
        chk("bp_stall", o_stall, 1);
        chk("bp_level", o_level, 16);
        chk("bp_overflow", o_overflow, 0);
        i_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain_valid", o_valid, 1);
            chk("bp_drain_index", o_index, i);
            cyc();
        end
        chk("bp_drained", o_level, 0);

        // Overflow: a bin forced while stalled is dropped and flagged.
        i_ready = 0;
        feed_core(24, 100, acc);
        i_bin_valid = 1; i_bin_data = 32'h1234_5678; i_bin_index = 12'hABC;
        cyc();
        idle();
        chk("ovf_set", o_overflow, 1);
        i_ready = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_valid && o_index == 12'hABC) seen = 1;
            cyc();
        end
        chk("ovf_dropped_bin_absent", seen, 0);
        i_ready = 0;
        feed_core(3, 200, acc);
        cyc(); cyc();
        i_clear = 1;
        cyc();
        i_clear = 0;
        chk("clear_overflow", o_overflow, 0);
        chk("clear_level", o_level, 0);

        // Frame end with N = 4.
        i_samp_number = 12'd4;
        i_ready = 0;
        for (int k = 0; k < 4; k++) begin
            i_bin_valid = 1; i_bin_data = $urandom; i_bin_index = IDX_W'(k);
            cyc();
        end
        idle();
        cyc(); cyc();
        i_ready = 1;
        done_cnt = 0; last_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_last) begin
                last_cnt++;
                chk("frame_last_index", o_index, 3);
            end
            prev_last_pop = o_valid & o_last & i_ready;
            cyc();
            chk("frame_done_timing", o_done, prev_last_pop);
            if (o_done) done_cnt++;
        end
        chk("frame_last_count", last_cnt, 1);
        chk("frame_done_count", done_cnt, 1);

        // Push and pop together with occupancy at capacity.
        i_samp_number = 12'd16;
        i_ready = 0;
        feed_core(16, 300, acc);
        chk("pp_level_before", o_level, 14);
        chk("pp_stall_before", o_stall, 1);
        i_ready = 1;
        cyc();
        chk("pp_level_same", o_level, 14);
        for (int i = 0; i < 10; i++) begin
            i_bin_valid = (m_occ() < DEPTH); i_bin_data = $urandom; i_bin_index = IDX_W'(400 + i);
            cyc();
        end
        idle();
        for (int i = 0; i < 20; i++) cyc();

        // Asynchronous reset with entries and both pipeline stages busy.
        i_ready = 0;
        for (int i = 0; i < 7; i++) begin
            i_bin_valid = 1; i_bin_data = $urandom; i_bin_index = IDX_W'(i);
            cyc();
        end
        chk("rst_mid_level", o_level, 5);
        #2 rst = 1;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        idle();
        @(posedge clk); #1;
        rst = 0;
        i_ready = 1;
        for (int i = 0; i < 5; i++) cyc();

        // Clear with a same-cycle push.
        i_ready = 0;
        for (int i = 0; i < 3; i++) begin
            i_bin_valid = 1; i_bin_data = $urandom; i_bin_index = IDX_W'(i);
            cyc();
        end
        i_clear = 1; i_bin_valid = 1; i_bin_data = $urandom;
        cyc();
        idle();
        chk("clear_push_level", o_level, 0);
        i_ready = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (o_valid) seen = 1;
        end
        chk("clear_push_nothing_out", seen, 0);

        // N = 0: never last, never done.
        i_samp_number = 12'd0;
        last_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            i_ready = ($urandom_range(0, 1) == 1);
            i_bin_valid = (m_occ() < DEPTH) && ($urandom_range(0, 2) != 0);
            i_bin_data = $urandom;
            i_bin_index = (i % 2 == 0) ? 12'hFFF : 12'h000;
            cyc();
            if (o_last) last_cnt++;
            if (o_done) done_cnt++;
        end
        idle();
        chk("n0_last_count", last_cnt, 0);
        chk("n0_done_count", done_cnt, 0);

        // Randomized traffic with bursty back-pressure, drops and rare clears.
        i_samp_number = 12'd8;
        for (int blk = 0; blk < 30; blk++) begin
            int rdy_bias;
            rdy_bias = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) begin
                i_ready     = ($urandom_range(0, 3) < rdy_bias);
                i_bin_valid = ($urandom_range(0, 3) != 0);
                i_bin_data  = $urandom;
                i_bin_index = IDX_W'($urandom_range(0, 9));
                i_clear     = ($urandom_range(0, 299) == 0);
                cyc();
            end
        end
        idle();
        i_ready = 1;
        for (int i = 0; i < 24; i++) cyc();
        chk("final_empty", o_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
